// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scanner with ghost blanking, 16-level
// PWM brightness, per-digit blink and frame-synchronous (tear-free) pattern update.
module sseg_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 128,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic [31:0] i_sseg,
  input  logic        i_valid,
  input  logic [3:0]  i_bright,
  input  logic [3:0]  i_blink_mask,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_an,
  output logic        o_frame
);

  localparam int unsigned SW = $clog2(DIGIT_CYCLES);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [7:0]    SEG_OFF    = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]    AN_OFF     = ACTIVE_LOW ? 4'hF : 4'h0;

  if (BLANK_CYCLES + 16 > DIGIT_CYCLES) begin : g_bad_slot
    $error("sseg_scan_driver: DIGIT_CYCLES must be >= BLANK_CYCLES+16");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("sseg_scan_driver: BLINK_FRAMES must be >= 1");
  end

  logic [SW-1:0] slot;
  logic [1:0]    digit;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [31:0]   pending;
  logic [31:0]   active;

  logic          boundary;
  logic          lit;
  logic [3:0]    pwm;
  logic [7:0]    seg_pat;
  logic [3:0]    an_hot;

  always_comb begin
    boundary = (slot == '0) && (digit == 2'd0);
    pwm      = 4'(slot - BLANK_END);
    lit      = (slot >= BLANK_END) && (pwm < i_bright)
               && !(blink_phase && i_blink_mask[digit]);
    seg_pat  = active[{digit, 3'b000} +: 8];
    an_hot   = 4'b0001 << digit;
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      slot        <= '0;
      digit       <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pending     <= '0;
      active      <= '0;
      o_seg       <= SEG_OFF;
      o_an        <= AN_OFF;
      o_frame     <= 1'b0;
    end else begin
      if (i_valid) pending <= i_sseg;

      if (slot == SLOT_LAST) begin
        slot  <= '0;
        digit <= digit + 2'd1;
      end else begin
        slot <= slot + SW'(1);
      end

      // A write landing on the boundary cycle is held for the next frame.
      if (boundary) begin
        active <= pending;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      o_frame <= boundary;
      o_an    <= lit ? (ACTIVE_LOW ? ~an_hot  : an_hot)  : AN_OFF;
      o_seg   <= lit ? (ACTIVE_LOW ? ~seg_pat : seg_pat) : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: reset, scan order, tear-free update,
// brightness, blink and mid-frame reset, with 64-cycle slots and 4 blank cycles.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_sseg;
  logic        i_valid;
  logic [3:0]  i_bright;
  logic [3:0]  i_blink_mask;
  logic [7:0]  o_seg;
  logic [3:0]  o_an;
  logic        o_frame;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .DIGIT_CYCLES (64),
    .BLANK_CYCLES (4),
    .BLINK_FRAMES (2),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .i_clk        (clk),
    .rst          (rst),
    .i_sseg       (i_sseg),
    .i_valid      (i_valid),
    .i_bright     (i_bright),
    .i_blink_mask (i_blink_mask),
    .o_seg        (o_seg),
    .o_an         (o_an),
    .o_frame      (o_frame)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Observes ncyc cycles of one frame (k = cycle index within the frame);
  // optionally pulses i_valid with wr_data during cycle wr_at.
  task automatic run_frame(input string name, input int ncyc, input logic [31:0] pat,
                           input logic phase, input int wr_at, input logic [31:0] wr_data);
    for (int k = 0; k < ncyc; k++) begin
      int         s;
      int         d;
      logic [3:0] pwm;
      logic       lit;
      logic [3:0] e_an;
      logic [7:0] e_seg;
      if (k == wr_at) begin
        i_valid = 1'b1;
        i_sseg  = wr_data;
      end
      tick();
      i_valid = 1'b0;
      s   = k % 64;
      d   = k / 64;
      lit = 1'b0;
      if (s >= 4) begin
        pwm = 4'((s - 4) % 16);
        lit = (pwm < i_bright) && !(phase && i_blink_mask[d]);
      end
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg = lit ? ~pat[8*d +: 8] : 8'hFF;
      check($sformatf("%s_an_k%0d", name, k), {4'h0, o_an}, {4'h0, e_an});
      check($sformatf("%s_seg_k%0d", name, k), o_seg, e_seg);
      check($sformatf("%s_frame_k%0d", name, k), {7'h0, o_frame}, {7'h0, (k == 0)});
    end
  endtask

  initial begin
    rst          = 1'b1;
    i_sseg       = '0;
    i_valid      = 1'b0;
    i_bright     = 4'd0;
    i_blink_mask = 4'b0000;

    repeat (5) begin
      tick();
      check("rst_an", {4'h0, o_an}, 8'h0F);
      check("rst_seg", o_seg, 8'hFF);
      check("rst_frame", {7'h0, o_frame}, 8'h00);
    end
    rst = 1'b0;

    // Frame 0: dark; pattern written mid-frame
    run_frame("f0_dark", 256, 32'h0, 1'b0, 128, 32'h4F5B063F);
    i_bright = 4'd15;
    run_frame("f1_scan", 256, 32'h4F5B063F, 1'b1, -1, 32'h0);
    // Write on the boundary cycle: old pattern kept for this frame
    run_frame("f2_old", 256, 32'h4F5B063F, 1'b1, 0, 32'hFFFFFFFF);
    run_frame("f3_new", 256, 32'hFFFFFFFF, 1'b0, -1, 32'h0);

    i_bright = 4'd0;
    run_frame("f4_b0", 256, 32'hFFFFFFFF, 1'b0, -1, 32'h0);
    i_bright = 4'd4;
    run_frame("f5_b4", 256, 32'hFFFFFFFF, 1'b1, -1, 32'h0);

    // Blink phase per frame since reset: 0,1,1,0,0,1,1,0,0,1,...
    i_bright     = 4'd15;
    i_blink_mask = 4'b0010;
    run_frame("f6_blink", 256, 32'hFFFFFFFF, 1'b1, -1, 32'h0);
    run_frame("f7_blink", 256, 32'hFFFFFFFF, 1'b0, -1, 32'h0);
    run_frame("f8_blink", 256, 32'hFFFFFFFF, 1'b0, -1, 32'h0);
    run_frame("f9_blink", 256, 32'hFFFFFFFF, 1'b1, -1, 32'h0);
    i_blink_mask = 4'b0000;

    // Up to digit 2, slot 29; reset is sampled in slot 30
    run_frame("f10_pre", 158, 32'hFFFFFFFF, 1'b1, -1, 32'h0);
    check("pre_rst_an", {4'h0, o_an}, 8'h0B);
    rst = 1'b1;
    tick();
    check("midrst_an", {4'h0, o_an}, 8'h0F);
    check("midrst_seg", o_seg, 8'hFF);
    check("midrst_frame", {7'h0, o_frame}, 8'h00);
    tick();
    check("midrst2_an", {4'h0, o_an}, 8'h0F);
    check("midrst2_seg", o_seg, 8'hFF);
    rst = 1'b0;

    run_frame("r0_dark", 256, 32'h0, 1'b0, -1, 32'h0);
    run_frame("r1_dark", 256, 32'h0, 1'b1, -1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
